// File: rtl/four_bit_checker.sv
// -----------------------------------------------------------------------------
// four_bit_checker
//
// Exhaustive self-test sequencer for a 4-bit adder.  A sweep walks a 9-bit
// vector index over all 512 combinations of {A, B, CARRY_IN}.  For each
// vector it waits SETTLE_CYCLES cycles for the adder to settle. It then
// compares {CARRY_OUT, S} against A+B+CARRY_IN and logs the result.
//
// Parameters
//   SETTLE_CYCLES  cycles spent in SETTLE for each vector (legal 1..15)
//
// Optional feature (compile-time macro)
//   FOUR_BIT_CHECKER_HALT_EN  when defined, the first mismatch ends the sweep
//                             immediately and idx stays on the failing vector.
//                             When undefined, all 512 vectors are always run.
//
// Ports
//   CLOCK       in   rising-edge clock
//   RESET       in   synchronous active-high reset
//   START       in   one-cycle sweep request (ignored while BUSY)
//   A, B        out  4-bit operands to the adder under test (idx[8:5], idx[4:1])
//   CARRY_IN    out  carry-in to the adder under test (idx[0])
//   S           in   adder sum
//   CARRY_OUT   in   adder carry-out
//   BUSY        out  sweep in progress (SETTLE or CHECK)
//   DONE        out  sweep finished; held until START or RESET
//   PASS        out  DONE with no mismatches
//   ERR_COUNT   out  mismatching vectors in the current or last sweep
//   FAIL_VALID  out  a mismatch has been captured in FAIL_VEC
//   FAIL_VEC    out  index of the first mismatching vector
// -----------------------------------------------------------------------------
module four_bit_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       CARRY_IN,
    input  logic [3:0] S,
    input  logic       CARRY_OUT,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [9:0] ERR_COUNT,
    output logic       FAIL_VALID,
    output logic [8:0] FAIL_VEC
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The settle counter runs 0 .. SETTLE_CYCLES-1, so SETTLE lasts exactly
    // SETTLE_CYCLES cycles and each vector takes SETTLE_CYCLES+1 cycles.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [8:0] IDX_LAST    = 9'd511;

    state_t     state_q, state_d;
    logic [8:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] err_q, err_d;
    logic       fail_valid_q, fail_valid_d;
    logic [8:0] fail_vec_q, fail_vec_d;

    logic [4:0] expected;
    logic       mismatch;

    // Operands come straight from the index so the adder sees a stable
    // vector for the whole SETTLE/CHECK window.
    assign A        = idx_q[8:5];
    assign B        = idx_q[4:1];
    assign CARRY_IN = idx_q[0];

    assign expected = {1'b0, A} + {1'b0, B} + {4'b0000, CARRY_IN};
    assign mismatch = (expected != {CARRY_OUT, S});

    assign BUSY       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign DONE       = (state_q == ST_DONE);
    assign PASS       = DONE && (err_q == 10'd0);
    assign ERR_COUNT  = err_q;
    assign FAIL_VALID = fail_valid_q;
    assign FAIL_VEC   = fail_vec_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // FAIL_VEC keeps its old value; FAIL_VALID says whether it
                // belongs to the sweep now being reported.
                if (START) begin
                    idx_d        = 9'd0;
                    err_d        = 10'd0;
                    fail_valid_d = 1'b0;
                    cnt_d        = 4'd0;
                    state_d      = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_CHECK: begin
                // At most 512 vectors are checked, so the 10-bit count
                // cannot overflow.
                if (mismatch) begin
                    err_d = err_q + 10'd1;
                    if (!fail_valid_q) begin
                        fail_vec_d   = idx_q;
                        fail_valid_d = 1'b1;
                    end
                end
`ifdef FOUR_BIT_CHECKER_HALT_EN
                if (mismatch || (idx_q == IDX_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end
`else
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            idx_q        <= 9'd0;
            cnt_q        <= 4'd0;
            err_q        <= 10'd0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 9'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

endmodule

// File: tb/tb_four_bit_checker.sv
// -----------------------------------------------------------------------------
// tb_four_bit_checker
//
// Bench for four_bit_checker.  A behavioural 4-bit adder with selectable
// faults (none, S[0] stuck at 0, CARRY_OUT stuck at 0) sits on the checker's
// operand outputs.  Each issued sweep pushes its expected final report onto
// a queue; a monitor pops it when DONE rises and compares it.
// Latency is counted with the edge that samples START as edge 1.
// -----------------------------------------------------------------------------
module tb_four_bit_checker;

    localparam int SC       = 2;
    localparam int FULL_LAT = 1 + 512 * (SC + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       busy, done, pass;
    logic [9:0] err_count;
    logic       fail_valid;
    logic [8:0] fail_vec;

    int fault = 0;
    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int lat;
        int err;
        int fv;
        int fvec;
        int pas;
        int idx_end;
        int start_edge;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    four_bit_checker #(.SETTLE_CYCLES(SC)) dut (
        .CLOCK      (clk),
        .RESET      (rst),
        .START      (start),
        .A          (a),
        .B          (b),
        .CARRY_IN   (cin),
        .S          (s),
        .CARRY_OUT  (cout),
        .BUSY       (busy),
        .DONE       (done),
        .PASS       (pass),
        .ERR_COUNT  (err_count),
        .FAIL_VALID (fail_valid),
        .FAIL_VEC   (fail_vec)
    );

    // Adder under test, with optional planted faults.
    always_comb begin
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (fault == 1) sum[0] = 1'b0;
        if (fault == 2) sum[4] = 1'b0;
        s    = sum[3:0];
        cout = sum[4];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare the final report whenever DONE rises.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_latency", cyc - mon_e.start_edge + 1, mon_e.lat);
                chk("err_count",    err_count,                 mon_e.err);
                chk("fail_valid",   fail_valid,                mon_e.fv);
                chk("fail_vec",     fail_vec,                  mon_e.fvec);
                chk("pass",         pass,                      mon_e.pas);
                chk("end_vector",   {a, b, cin},               mon_e.idx_end);
                chk("busy_at_done", busy,                      0);
            end
        end
        done_prev <= done;
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_a"},          a,          0);
        chk({tag, "_b"},          b,          0);
        chk({tag, "_cin"},        cin,        0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_done"},       done,       0);
        chk({tag, "_pass"},       pass,       0);
        chk({tag, "_err_count"},  err_count,  0);
        chk({tag, "_fail_valid"}, fail_valid, 0);
        chk({tag, "_fail_vec"},   fail_vec,   0);
    endtask

    // Pulse START for one cycle and record the expected report.  Returns at
    // the falling edge just after the edge that sampled START.
    task automatic issue_sweep(input int lat, input int err, input int fv,
                               input int fvec, input int pas, input int idx_end);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        e.lat = lat; e.err = err; e.fv = fv; e.fvec = fvec;
        e.pas = pas; e.idx_end = idx_end; e.start_edge = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fault = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Good adder.  Also: first vector timing, START while busy ignored,
        // and results held in DONE.
        issue_sweep(FULL_LAT, 0, 0, 0, 1, 511);
        chk("first_vec", {a, b, cin}, 0);
        chk("busy_sweep", busy, 1);
        repeat (SC + 1) @(negedge clk);
        chk("second_vec", {a, b, cin}, 1);
        repeat (50) @(negedge clk);
        chk("busy_mid", busy, 1);
        chk("done_mid", done, 0);
        chk("pass_mid", pass, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(FULL_LAT + 20);
        repeat (10) @(negedge clk);
        chk("hold_done",      done,        1);
        chk("hold_pass",      pass,        1);
        chk("hold_err_count", err_count,   0);
        chk("hold_vec",       {a, b, cin}, 511);
        chk("hold_busy",      busy,        0);

        // S[0] stuck at 0: first failure is vector 1 (A=0,B=0,CIN=1).
        fault = 1;
`ifdef FOUR_BIT_CHECKER_HALT_EN
        issue_sweep(1 + 2 * (SC + 1), 1, 1, 1, 0, 1);
`else
        issue_sweep(FULL_LAT, 256, 1, 1, 0, 511);
`endif
        chk("err_cleared_on_start", err_count, 0);
        wait_done(FULL_LAT + 20);

        // CARRY_OUT stuck at 0: every vector with sum >= 16 fails; the first
        // is A=0, B=15, CIN=1 (index 31).
        fault = 2;
`ifdef FOUR_BIT_CHECKER_HALT_EN
        issue_sweep(1 + 32 * (SC + 1), 1, 1, 31, 0, 31);
`else
        issue_sweep(FULL_LAT, 256, 1, 31, 0, 511);
`endif
        chk("fail_valid_cleared_on_start", fail_valid, 0);
        wait_done(FULL_LAT + 20);

        // Reset 100 cycles into a sweep aborts it; no report is expected.
        fault = 0;
        issue_sweep(FULL_LAT, 0, 0, 0, 1, 511);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        check_reset_state("abort");
        repeat (20) @(negedge clk);
        chk("abort_stays_idle", busy, 0);

        // Restart from idx 0 after the abort.
        issue_sweep(FULL_LAT, 0, 0, 0, 1, 511);
        chk("restart_vec", {a, b, cin}, 0);
        wait_done(FULL_LAT + 20);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/four_bit_checker.md
FOUR_BIT_CHECKER -- requirements
Module: four_bit_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, DUT settle cycles per vector (legal range 1..15).
REQ-002 SHALL have port CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port START  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port A  output  4  operand A driven to the four_bit adder under test.
REQ-006 SHALL have port B  output  4  operand B driven to the DUT.
REQ-007 SHALL have port CARRY_IN  output  1  carry-in driven to the DUT.
REQ-008 SHALL have port S  input  4  DUT sum.
REQ-009 SHALL have port CARRY_OUT  input  1  DUT carry-out.
REQ-010 SHALL have port BUSY  output  1  high while a sweep is in progress.
REQ-011 SHALL have port DONE  output  1  high from sweep completion until the next START or RESET.
REQ-012 SHALL have port PASS  output  1  valid with DONE; 1 when ERR_COUNT==0.
REQ-013 SHALL have port ERR_COUNT  output  10  number of mismatching vectors in the current or last sweep.
REQ-014 SHALL have port FAIL_VALID  output  1  a mismatch has been captured.
REQ-015 SHALL have port FAIL_VEC  output  9  index of the first mismatching vector.

Function
REQ-016 SHALL hold a 9-bit vector index idx; A=idx[8:5], B=idx[4:1], CARRY_IN=idx[0], driven combinationally from idx.
REQ-017 SHALL compute expected = A+B+CARRY_IN in 5 bits, compared against {CARRY_OUT,S}.
REQ-018 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-019 IDLE/DONE: START=1 -> idx<=0, ERR_COUNT<=0, FAIL_VALID<=0, settle counter<=0, next state SETTLE.
REQ-020 SETTLE: stay exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-021 CHECK: on mismatch, ERR_COUNT increments; if FAIL_VALID==0, FAIL_VEC<=idx and FAIL_VALID<=1.
REQ-022 CHECK: if idx==511 go to DONE, else idx<=idx+1 and go to SETTLE; idx SHALL NOT wrap.
REQ-023 Each vector SHALL take SETTLE_CYCLES+1 cycles; DONE SHALL rise 1+512*(SETTLE_CYCLES+1) cycles after the edge sampling START.
REQ-024 BUSY=1 in SETTLE and CHECK only; DONE=1 in DONE state only; PASS=DONE && (ERR_COUNT==0).
REQ-025 START while BUSY SHALL be ignored.
REQ-026 In DONE, idx, ERR_COUNT, and FAIL_* SHALL hold until START or RESET.
REQ-027 ERR_COUNT SHALL never exceed 512; no saturation logic is needed.

Reset
REQ-028 RESET=1 at any edge SHALL force IDLE, idx=0 (A=0, B=0, CARRY_IN=0), BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, FAIL_VALID=0, FAIL_VEC=0, and settle counter=0.
REQ-029 RESET SHALL take priority over START; RESET mid-sweep SHALL abort with no partial result retained.

Configuration
REQ-030 Macro FOUR_BIT_CHECKER_HALT_EN: when defined, the first mismatch in CHECK SHALL go directly to DONE with idx held at the failing vector (ERR_COUNT=1); when undefined, the full 512-vector sweep SHALL always complete.

Verification
REQ-031 Correct adder, SETTLE_CYCLES=2, START pulse -> DONE rises 1537 cycles later, PASS=1, ERR_COUNT=0, FAIL_VALID=0.
REQ-032 DUT with S[0] stuck at 0, macro undefined -> ERR_COUNT=256, FAIL_VALID=1, FAIL_VEC=1, PASS=0.
REQ-033 DUT with CARRY_OUT stuck at 0, macro undefined -> ERR_COUNT=256, FAIL_VEC=31 (A=0, B=15, CARRY_IN=1).
REQ-034 Macro defined, S[0] stuck at 0 -> DONE after 1+2*(SETTLE_CYCLES+1) cycles, ERR_COUNT=1, A=0, B=0, CARRY_IN=1 held.
REQ-035 RESET asserted 100 cycles into a sweep -> next edge: IDLE, all outputs 0; a later START restarts from idx=0.
REQ-036 START pulsed again while BUSY -> no effect; DONE timing is unchanged from the first START.
